// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32I core: stage enables, NOP flushes,
// EX forwarding selects, saturating stall/flush counters and memory-timeout error.
module hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      id_instr_i,
  input  logic             id_is_rs2_i,
  input  logic [31:0]      ex_instr_i,
  input  logic             ex_is_rs2_i,
  input  logic             ex_is_load_i,
  input  logic             ex_rd_wren_i,
  input  logic [31:0]      mem_instr_i,
  input  logic             mem_rd_wren_i,
  input  logic [31:0]      wb_instr_i,
  input  logic             wb_rd_wren_i,
  input  logic             br_taken_i,
  input  logic             dmem_busy_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_o
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic       load_use, freeze, redirect, stall_evt;

  assign id_rs1 = id_instr_i[19:15];
  assign id_rs2 = id_instr_i[24:20];
  assign ex_rd  = ex_instr_i[11:7];
  assign ex_rs1 = ex_instr_i[19:15];
  assign ex_rs2 = ex_instr_i[24:20];
  assign mem_rd = mem_instr_i[11:7];
  assign wb_rd  = wb_instr_i[11:7];

  assign load_use = ex_is_load_i && ex_rd_wren_i && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (id_is_rs2_i && (ex_rd == id_rs2)));
  assign freeze   = dmem_busy_i;
  assign redirect = !dmem_busy_i && br_taken_i;
  assign stall_evt = freeze || (!br_taken_i && load_use);

  always_comb begin
    pc_en_o       = 1'b0;
    if_id_en_o    = 1'b0;
    id_ex_en_o    = 1'b0;
    ex_mem_en_o   = 1'b0;
    mem_wb_en_o   = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    fwd_a_sel_o   = 2'b00;
    fwd_b_sel_o   = 2'b00;
    if (!rst_i) begin
      if (freeze) begin
        pc_en_o = 1'b0;
      end else if (redirect) begin
        {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = 5'b11111;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (load_use) begin
        {id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = 3'b111;
        id_ex_flush_o = 1'b1;
      end else begin
        {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = 5'b11111;
      end

      // MEM is the younger producer, so it wins over WB
      if (mem_rd_wren_i && (mem_rd != 5'd0) && (mem_rd == ex_rs1))
        fwd_a_sel_o = 2'b01;
      else if (wb_rd_wren_i && (wb_rd != 5'd0) && (wb_rd == ex_rs1))
        fwd_a_sel_o = 2'b10;

      if (ex_is_rs2_i) begin
        if (mem_rd_wren_i && (mem_rd != 5'd0) && (mem_rd == ex_rs2))
          fwd_b_sel_o = 2'b01;
        else if (wb_rd_wren_i && (wb_rd != 5'd0) && (wb_rd == ex_rs2))
          fwd_b_sel_o = 2'b10;
      end
    end
  end

  // wait_cnt holds the number of consecutive busy cycles already completed;
  // the first busy cycle is seen in RUN, so it is loaded as 1 there.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= RUN;
      wait_cnt    <= '0;
      err_o       <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= dmem_busy_i ? WAIT_W'(1) : '0;
          if (dmem_busy_i) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (dmem_busy_i) begin
            if (wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + WAIT_W'(1);
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase

      if (dmem_busy_i && (wait_cnt == WAIT_LAST)) err_o <= 1'b1;

      if (stall_evt && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (redirect && (flush_cnt_o != {CNT_W{1'b1}}))
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a combinational vector table plus hand-built
// multi-cycle sequences for stall, freeze, timeout and counter saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] id_instr, ex_instr, mem_instr, wb_instr;
  logic        id_is_rs2, ex_is_rs2, ex_is_load, ex_rd_wren;
  logic        mem_rd_wren, wb_rd_wren, br_taken, dmem_busy;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, err;
  logic [1:0]  fwd_a, fwd_b;
  logic [2:0]  stall_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(3), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_instr_i(id_instr), .id_is_rs2_i(id_is_rs2),
    .ex_instr_i(ex_instr), .ex_is_rs2_i(ex_is_rs2),
    .ex_is_load_i(ex_is_load), .ex_rd_wren_i(ex_rd_wren),
    .mem_instr_i(mem_instr), .mem_rd_wren_i(mem_rd_wren),
    .wb_instr_i(wb_instr), .wb_rd_wren_i(wb_rd_wren),
    .br_taken_i(br_taken), .dmem_busy_i(dmem_busy),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en),
    .ex_mem_en_o(ex_mem_en), .mem_wb_en_o(mem_wb_en),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
    .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .err_o(err)
  );

  typedef struct {
    logic [31:0] id_instr;
    logic        id_is_rs2;
    logic [31:0] ex_instr;
    logic        ex_is_rs2, ex_is_load, ex_rd_wren;
    logic [31:0] mem_instr;
    logic        mem_rd_wren;
    logic [31:0] wb_instr;
    logic        wb_rd_wren, br, busy;
    logic [4:0]  exp_en;
    logic [1:0]  exp_flush, exp_a, exp_b;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic vec_t mkVec(
    input logic [31:0] idi, input logic idr2,
    input logic [31:0] exi, input logic exr2, input logic exld, input logic exwr,
    input logic [31:0] memi, input logic memwr,
    input logic [31:0] wbi, input logic wbwr,
    input logic br, input logic busy,
    input logic [4:0] en, input logic [1:0] fl, input logic [1:0] a, input logic [1:0] b);
    vec_t v;
    v.id_instr = idi;   v.id_is_rs2 = idr2;
    v.ex_instr = exi;   v.ex_is_rs2 = exr2; v.ex_is_load = exld; v.ex_rd_wren = exwr;
    v.mem_instr = memi; v.mem_rd_wren = memwr;
    v.wb_instr = wbi;   v.wb_rd_wren = wbwr;
    v.br = br; v.busy = busy;
    v.exp_en = en; v.exp_flush = fl; v.exp_a = a; v.exp_b = b;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    id_instr = v.id_instr;   id_is_rs2 = v.id_is_rs2;
    ex_instr = v.ex_instr;   ex_is_rs2 = v.ex_is_rs2;
    ex_is_load = v.ex_is_load; ex_rd_wren = v.ex_rd_wren;
    mem_instr = v.mem_instr; mem_rd_wren = v.mem_rd_wren;
    wb_instr = v.wb_instr;   wb_rd_wren = v.wb_rd_wren;
    br_taken = v.br;         dmem_busy = v.busy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic setIdle();
    applyStimulus(mkVec(32'h13, 1'b0, 32'h13, 1'b0, 1'b0, 1'b0, 32'h13, 1'b0,
                        32'h13, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'd0, 2'd0));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    setIdle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [4:0] enBus();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  endfunction

  vec_t lu;

  initial begin
    // Combinational truth table: ID/EX/MEM/WB contents against enables, flushes, selects
    vecs.push_back(mkVec(mk(6,2,3),1, mk(4,8,9),1,0,1, mk(10,0,0),1, mk(11,0,0),1, 0,0, 5'b11111,2'b00,2'b00,2'b00));
    vecs.push_back(mkVec(mk(6,5,1),1, mk(5,1,0),0,1,1, mk(0,0,0),0, mk(0,0,0),0, 0,0, 5'b00111,2'b01,2'b00,2'b00));
    vecs.push_back(mkVec(mk(6,1,5),1, mk(5,1,0),0,1,1, mk(0,0,0),0, mk(0,0,0),0, 0,0, 5'b00111,2'b01,2'b00,2'b00));
    vecs.push_back(mkVec(mk(6,1,5),0, mk(5,1,0),0,1,1, mk(0,0,0),0, mk(0,0,0),0, 0,0, 5'b11111,2'b00,2'b00,2'b00));
    vecs.push_back(mkVec(mk(6,0,2),1, mk(0,1,0),0,1,1, mk(0,0,0),0, mk(0,0,0),0, 0,0, 5'b11111,2'b00,2'b00,2'b00));
    vecs.push_back(mkVec(mk(6,5,1),1, mk(5,1,0),0,1,0, mk(0,0,0),0, mk(0,0,0),0, 0,0, 5'b11111,2'b00,2'b00,2'b00));
    vecs.push_back(mkVec(mk(6,5,1),1, mk(5,1,0),0,1,1, mk(0,0,0),0, mk(0,0,0),0, 1,0, 5'b11111,2'b11,2'b00,2'b00));
    vecs.push_back(mkVec(mk(6,5,1),1, mk(5,1,0),0,1,1, mk(0,0,0),0, mk(0,0,0),0, 1,1, 5'b00000,2'b00,2'b00,2'b00));
    vecs.push_back(mkVec(mk(1,2,3),0, mk(8,7,7),1,0,1, mk(7,0,0),1, mk(7,0,0),1, 0,0, 5'b11111,2'b00,2'b01,2'b01));
    vecs.push_back(mkVec(mk(1,2,3),0, mk(8,7,7),1,0,1, mk(0,7,7),1, mk(7,0,0),1, 0,0, 5'b11111,2'b00,2'b10,2'b10));
    vecs.push_back(mkVec(mk(1,2,3),0, mk(8,7,7),0,0,1, mk(7,0,0),1, mk(7,0,0),1, 0,0, 5'b11111,2'b00,2'b01,2'b00));
    vecs.push_back(mkVec(mk(1,2,3),0, mk(8,7,7),1,0,1, mk(7,0,0),0, mk(7,0,0),1, 0,0, 5'b11111,2'b00,2'b10,2'b10));
    vecs.push_back(mkVec(mk(1,2,3),0, mk(8,3,7),1,0,1, mk(3,0,0),1, mk(7,0,0),1, 0,0, 5'b11111,2'b00,2'b01,2'b10));
    vecs.push_back(mkVec(mk(1,2,3),0, mk(8,0,0),1,0,1, mk(0,0,0),1, mk(0,0,0),1, 0,0, 5'b11111,2'b00,2'b00,2'b00));

    lu = vecs[1];

    // Reset state with hazard-free traffic on the inputs
    applyStimulus(vecs[8]);
    #2;
    checkOutput("reset_en", 32'(enBus()), 32'd0);
    checkOutput("reset_flush", 32'({if_id_flush, id_ex_flush}), 32'd0);
    checkOutput("reset_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    checkOutput("reset_cnt", 32'({stall_cnt, flush_cnt, err}), 32'd0);

    resetDut();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_en", i), 32'(enBus()), 32'(vecs[i].exp_en));
      checkOutput($sformatf("vec%0d_flush", i), 32'({if_id_flush, id_ex_flush}), 32'(vecs[i].exp_flush));
      checkOutput($sformatf("vec%0d_fwd_a", i), 32'(fwd_a), 32'(vecs[i].exp_a));
      checkOutput($sformatf("vec%0d_fwd_b", i), 32'(fwd_b), 32'(vecs[i].exp_b));
      nextCycle();
    end

    // Load-use: one stall cycle, then the dependent add forwards from MEM
    resetDut();
    applyStimulus(lu);
    #1;
    checkOutput("lu_en", 32'(enBus()), 32'b00111);
    checkOutput("lu_flush", 32'({if_id_flush, id_ex_flush}), 32'b01);
    checkOutput("lu_cnt_before", 32'(stall_cnt), 32'd0);
    nextCycle();
    applyStimulus(mkVec(mk(7,8,9),1, mk(6,5,1),1,0,1, mk(5,1,0),1, 32'h13,0, 0,0, 5'd0,2'd0,2'd0,2'd0));
    #1;
    checkOutput("lu_cnt_after", 32'(stall_cnt), 32'd1);
    checkOutput("lu_next_en", 32'(enBus()), 32'b11111);
    checkOutput("lu_next_flush", 32'({if_id_flush, id_ex_flush}), 32'b00);
    checkOutput("lu_next_fwd_a", 32'(fwd_a), 32'b01);
    nextCycle();
    checkOutput("lu_cnt_hold", 32'(stall_cnt), 32'd1);

    // Redirect wins over a simultaneous load-use
    resetDut();
    lu.br = 1'b1;
    applyStimulus(lu);
    #1;
    checkOutput("rd_lu_en", 32'(enBus()), 32'b11111);
    checkOutput("rd_lu_flush", 32'({if_id_flush, id_ex_flush}), 32'b11);
    nextCycle();
    setIdle();
    #1;
    checkOutput("rd_lu_flush_cnt", 32'(flush_cnt), 32'd1);
    checkOutput("rd_lu_stall_cnt", 32'(stall_cnt), 32'd0);

    // Three frozen cycles with a pending branch, then the redirect fires
    resetDut();
    br_taken = 1'b1;
    dmem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("frz%0d_en", k), 32'(enBus()), 32'd0);
      checkOutput($sformatf("frz%0d_flush", k), 32'({if_id_flush, id_ex_flush}), 32'd0);
      nextCycle();
    end
    dmem_busy = 1'b0;
    #1;
    checkOutput("frz_redirect_en", 32'(enBus()), 32'b11111);
    checkOutput("frz_redirect_flush", 32'({if_id_flush, id_ex_flush}), 32'b11);
    checkOutput("frz_flush_cnt_before", 32'(flush_cnt), 32'd0);
    nextCycle();
    br_taken = 1'b0;
    #1;
    checkOutput("frz_stall_cnt", 32'(stall_cnt), 32'd3);
    checkOutput("frz_flush_cnt", 32'(flush_cnt), 32'd1);
    checkOutput("frz_no_err", 32'(err), 32'd0);

    // Timeout: six busy cycles, err rises after the fourth busy edge and sticks
    resetDut();
    dmem_busy = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      nextCycle();
      if (k == 6) dmem_busy = 1'b0;
      #1;
      checkOutput($sformatf("tmo_edge%0d_err", k), 32'(err), (k >= 4) ? 32'd1 : 32'd0);
    end
    repeat (2) nextCycle();
    checkOutput("tmo_sticky", 32'(err), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("tmo_async_clear", 32'(err), 32'd0);
    checkOutput("tmo_rst_en", 32'(enBus()), 32'd0);
    checkOutput("tmo_rst_cnt", 32'(stall_cnt), 32'd0);

    // Saturation: nine load-use cycles on a 3-bit counter
    resetDut();
    lu.br = 1'b0;
    applyStimulus(lu);
    for (int k = 1; k <= 9; k++) begin
      nextCycle();
      if (k == 6) checkOutput("sat_6", 32'(stall_cnt), 32'd6);
      if (k == 7) checkOutput("sat_7", 32'(stall_cnt), 32'd7);
    end
    checkOutput("sat_9", 32'(stall_cnt), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I forwarding core. It sequences the pipeline registers (PC, IF_ID, ID_EX, EX_MEM, MEM_WB) and handles four hazard cases:
- load-use stalls
- taken-branch flushes
- data-memory wait freezes
- EX-stage operand forwarding selects

It also keeps saturating stall and flush counters and a sticky memory-timeout error. It sits beside the datapath in the top level and drives every stage `enable_i`, plus the flush controls that inject NOPs (`32'h00000013`) into IF_ID and ID_EX.

## Interface
Parameters:
- `CNT_W`, 32: width of the performance counters.
- `TIMEOUT`, 1024: number of consecutive `dmem_busy_i` cycles that raises `err_o`.

Ports:
- `clk_i`, in, 1: clock; all registers update on the rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `id_instr_i`, in, 32: instruction in ID; rs1 = [19:15], rs2 = [24:20].
- `id_is_rs2_i`, in, 1: the ID instruction reads rs2.
- `ex_instr_i`, in, 32: instruction in EX; rd = [11:7], rs1 = [19:15], rs2 = [24:20].
- `ex_is_rs2_i`, `ex_is_load_i`, `ex_rd_wren_i`, in, 1 each: EX control bits taken from the ID_EX outputs.
- `mem_instr_i`, in, 32: instruction in MEM.
- `mem_rd_wren_i`, in, 1: the MEM instruction writes rd.
- `wb_instr_i`, in, 32: instruction in WB.
- `wb_rd_wren_i`, in, 1: the WB instruction writes rd.
- `br_taken_i`, in, 1: the EX branch/jump resolved taken. The core predicts not-taken.
- `dmem_busy_i`, in, 1: data memory not ready; the whole pipeline must hold.
- `pc_en_o`, `if_id_en_o`, `id_ex_en_o`, `ex_mem_en_o`, `mem_wb_en_o`, out, 1 each: stage enables.
- `if_id_flush_o`, `id_ex_flush_o`, out, 1 each: load a NOP into the stage register on the next edge.
- `fwd_a_sel_o`, `fwd_b_sel_o`, out, 2 each: EX operand source. 00 = register file, 01 = MEM result, 10 = WB result.
- `stall_cnt_o`, `flush_cnt_o`, out, `CNT_W` each: saturating event counters.
- `err_o`, out, 1: sticky memory-timeout error.

## Operation
- **Hazard definitions** (all use x0 exclusion, i.e. rd != 0):
  - **load_use:** `ex_is_load_i` & `ex_rd_wren_i` & ex_rd != 0 & (ex_rd == id_rs1 | (`id_is_rs2_i` & ex_rd == id_rs2)).
  - **freeze:** `dmem_busy_i`.
  - **redirect:** `br_taken_i`.
- **Priority:** freeze > redirect > load_use > run.
  - **freeze:** all five enables 0; both flushes 0.
  - **redirect:** all enables 1; `if_id_flush_o` = `id_ex_flush_o` = 1. The PC loads the branch target.
  - **load_use:** `pc_en_o` = `if_id_en_o` = 0; `id_ex_flush_o` = 1 (bubble); EX/MEM/WB enables 1.
  - **run:** all enables 1; flushes 0.
- **Stall/flush outputs** are combinational from the inputs and gated by reset. While `rst_i` = 1, every enable, flush and select is 0.
- **Forwarding for A:**
  - 01 if `mem_rd_wren_i` & mem_rd != 0 & mem_rd == ex_rs1.
  - Otherwise 10 if the same condition holds for WB.
  - Otherwise 00.
  - MEM has priority over WB.
- **Forwarding for B:** same rule applied to ex_rs2, and additionally gated by `ex_is_rs2_i` (00 when clear).
- **FSM** (2 states, registered):
  - RUN → MEM_WAIT when `dmem_busy_i` = 1.
  - MEM_WAIT → RUN when `dmem_busy_i` = 0.
  - Reset state: RUN.
- **Wait counter:**
  - Cleared in RUN; increments each MEM_WAIT cycle with `dmem_busy_i` = 1.
  - When it reaches `TIMEOUT`-1 while still busy, `err_o` sets on the next edge.
  - `err_o` clears only on reset.
- **stall_cnt:** +1 per cycle in which load_use or freeze is the selected action.
- **flush_cnt:** +1 per redirect cycle.
- **Counters** saturate at all-ones and never wrap.

## Timing
- **Reset:** asynchronous assert. State = RUN; wait counter, `stall_cnt_o`, `flush_cnt_o` and `err_o` = 0; all enables, flushes and selects = 0.
- **Deassertion:** takes effect at the first rising edge after `rst_i` falls.
- **Latency:** enables, flushes and selects have zero latency (same cycle as the inputs). Counters, FSM and `err_o` update at the edge that ends the qualifying cycle.
- **Load-use duration:** exactly one cycle per load. On the next edge the load moves to MEM, and the bubble sits in EX, so the hazard clears by itself. The dependent instruction then forwards via 01.
- **Branch under freeze:** no flush is issued while frozen. EX is held, so `br_taken_i` persists and the redirect fires in the first cycle after `dmem_busy_i` drops.
- **Simultaneous redirect and load_use:** only the redirect is taken; `stall_cnt_o` does not increment.
- **Reset mid-freeze:** the FSM returns to RUN, the wait counter clears, and `err_o` clears.

## Test plan
- **Load-use stall:** `lw x5` in EX, `add x6,x5,x1` in ID → exactly one cycle of `pc_en_o`=0, `if_id_en_o`=0, `id_ex_flush_o`=1; `stall_cnt_o` goes 0→1. The next cycle `fwd_a_sel_o`=01.
- **Forwarding priority:** x7 written in both MEM and WB, EX reads x7 as rs1 and rs2 with `ex_is_rs2_i`=1 → both selects 01. With MEM rd=x0 instead → 10.
- **Redirect over load_use:** `br_taken_i`=1 together with load_use → both flushes 1, `pc_en_o`=1, `flush_cnt_o`=1, `stall_cnt_o` unchanged.
- **Memory freeze with pending branch:** `dmem_busy_i` high for 3 cycles while `br_taken_i`=1 → all enables 0 and flushes 0 for 3 cycles, then one redirect cycle; `stall_cnt_o`=3.
- **Timeout:** `TIMEOUT`=4, `dmem_busy_i` held 6 cycles → `err_o` rises after the 4th busy edge and stays 1 after busy drops; asserting `rst_i` clears it asynchronously.
- **Saturation:** `CNT_W`=3 with 9 load-use events → `stall_cnt_o` holds at 7.
